// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between N_REQ
// writeback sources. One accepted write per cycle, presented to the register
// file one cycle after the handshake. x0 writes are accepted and dropped.
module regfile_wb_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hold,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*AW-1:0]   req_waddr,
  input  logic [N_REQ*DW-1:0]   req_wdata,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  output logic                  fwd_valid,
  output logic [2:0]            grant_id
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] r_rr_ptr;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic [2:0]    r_grant_id;

  logic          w_gnt_vld;
  logic [PW-1:0] w_gnt_idx;
  logic [PW-1:0] w_cand;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_data;
  logic [PW-1:0] w_ptr_next;

  // Find the first valid requester at or after the round-robin pointer.
  always_comb begin : arb_search
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = PW'((32'(r_rr_ptr) + k) % N_REQ);
      if (!w_gnt_vld && req_valid[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (hold || !reset_n) begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
    end
  end

  // One-hot ready to the granted requester only.
  always_comb begin : ready_decode
    req_ready = '0;
    if (w_gnt_vld) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Select the granted requester's address and data.
  always_comb begin : payload_mux
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_gnt_idx == PW'(k)) begin
        w_sel_addr = req_waddr[k*AW +: AW];
        w_sel_data = req_wdata[k*DW +: DW];
      end
    end
  end

  // Pointer moves just past the winner, wrapping at N_REQ.
  always_comb begin : ptr_next
    w_ptr_next = (w_gnt_idx == PW'(N_REQ - 1)) ? '0 : w_gnt_idx + PW'(1);
  end

  // Output register and pointer; x0 writes complete the handshake but never assert we.
  always_ff @(posedge clk or negedge reset_n) begin : out_reg
    if (!reset_n) begin
      r_rr_ptr   <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_grant_id <= '0;
    end else if (w_gnt_vld) begin
      r_rr_ptr   <= w_ptr_next;
      r_we       <= (w_sel_addr != '0);
      r_waddr    <= w_sel_addr;
      r_wdata    <= w_sel_data;
      r_grant_id <= 3'(w_gnt_idx);
    end else begin
      r_we       <= 1'b0;
    end
  end

  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign fwd_valid = r_we;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset corner case,
// then randomized traffic against a behavioural round-robin model.
module tb_regfile_wb_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_waddr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic            fwd_valid;
  logic [2:0]      grant_id;

  regfile_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .hold(hold),
    .req_valid(req_valid), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data tag used by the table so expected data follows from winner and address.
  function automatic logic [31:0] tag(input int g, input logic [4:0] a);
    return 32'hC0DE_0000 | 32'(g << 8) | 32'(a);
  endfunction

  // Drive one cycle of inputs, sample ready mid-cycle, then sample registered outputs after the edge.
  task automatic apply(input logic h, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                       input logic [N*DW-1:0] d, output logic [N-1:0] rdy, output logic we,
                       output logic fv, output logic [AW-1:0] wa, output logic [DW-1:0] wd,
                       output logic [2:0] gid);
    hold = h; req_valid = v; req_waddr = a; req_wdata = d;
    #1 rdy = req_ready;
    @(posedge clk);
    #1;
    we = rf_we; fv = fwd_valid; wa = rf_waddr; wd = rf_wdata; gid = grant_id;
  endtask

  typedef struct {
    logic       h;
    logic [2:0] v;
    logic [4:0] a0, a1, a2;
    logic [2:0] er;
    logic       ewe;
    logic [4:0] ea;
    logic [2:0] eg;
  } vec_t;

  vec_t tbl[14];

  logic [N-1:0]  o_rdy;
  logic          o_we, o_fv;
  logic [AW-1:0] o_wa;
  logic [DW-1:0] o_wd;
  logic [2:0]    o_gid;

  // Behavioural model state for the random phase.
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_gid;
  logic          pv[N];
  logic [AW-1:0] pa[N];
  logic [DW-1:0] pd[N];

  initial begin
    //        h  v     a0 a1 a2  er    we ea gid
    tbl[0]  = '{0, 3'b001, 5, 0, 0, 3'b001, 1, 5, 0};
    tbl[1]  = '{0, 3'b111, 1, 2, 3, 3'b010, 1, 2, 1};
    tbl[2]  = '{0, 3'b111, 1, 2, 3, 3'b100, 1, 3, 2};
    tbl[3]  = '{0, 3'b111, 1, 2, 3, 3'b001, 1, 1, 0};
    tbl[4]  = '{0, 3'b111, 1, 2, 3, 3'b010, 1, 2, 1};
    tbl[5]  = '{0, 3'b111, 1, 2, 3, 3'b100, 1, 3, 2};
    tbl[6]  = '{0, 3'b010, 0, 0, 0, 3'b010, 0, 0, 1};
    tbl[7]  = '{1, 3'b111, 1, 2, 3, 3'b000, 0, 0, 1};
    tbl[8]  = '{1, 3'b111, 1, 2, 3, 3'b000, 0, 0, 1};
    tbl[9]  = '{1, 3'b111, 1, 2, 3, 3'b000, 0, 0, 1};
    tbl[10] = '{0, 3'b111, 1, 2, 3, 3'b100, 1, 3, 2};
    tbl[11] = '{0, 3'b101, 1, 2, 3, 3'b001, 1, 1, 0};
    tbl[12] = '{0, 3'b101, 1, 2, 3, 3'b100, 1, 3, 2};
    tbl[13] = '{0, 3'b000, 1, 2, 3, 3'b000, 0, 3, 2};

    // Reset state, with requests already valid.
    reset_n = 1'b0; hold = 1'b0; req_valid = 3'b111;
    req_waddr = {5'd3, 5'd2, 5'd1}; req_wdata = '1;
    #12;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_we", 32'(rf_we), 32'h0);
    chk("rst_fwd", 32'(fwd_valid), 32'h0);
    chk("rst_waddr", 32'(rf_waddr), 32'h0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].h, tbl[i].v, {tbl[i].a2, tbl[i].a1, tbl[i].a0},
            {tag(2, tbl[i].a2), tag(1, tbl[i].a1), tag(0, tbl[i].a0)},
            o_rdy, o_we, o_fv, o_wa, o_wd, o_gid);
      chk($sformatf("tbl%0d_ready", i), 32'(o_rdy), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_we", i), 32'(o_we), 32'(tbl[i].ewe));
      chk($sformatf("tbl%0d_fwd", i), 32'(o_fv), 32'(tbl[i].ewe));
      chk($sformatf("tbl%0d_waddr", i), 32'(o_wa), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d_wdata", i), o_wd, tag(int'(tbl[i].eg), tbl[i].ea));
      chk($sformatf("tbl%0d_gid", i), 32'(o_gid), 32'(tbl[i].eg));
    end

    // Reset asserted while a write is being presented.
    apply(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11},
          o_rdy, o_we, o_fv, o_wa, o_wd, o_gid);
    chk("mid_pre_we", 32'(o_we), 32'h1);
    chk("mid_pre_waddr", 32'(o_wa), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(rf_we), 32'h0);
    chk("mid_rst_fwd", 32'(fwd_valid), 32'h0);
    chk("mid_rst_waddr", 32'(rf_waddr), 32'h0);
    chk("mid_rst_gid", 32'(grant_id), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    apply(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11},
          o_rdy, o_we, o_fv, o_wa, o_wd, o_gid);
    chk("post_rst_ready", 32'(o_rdy), 32'h1);
    chk("post_rst_gid", 32'(o_gid), 32'h0);
    chk("post_rst_wdata", o_wd, 32'h11);

    // Randomized traffic from a fresh reset against the model.
    reset_n = 1'b0; #1;
    @(posedge clk); #1 reset_n = 1'b1;
    m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = 0;
    for (int i = 0; i < N; i++) begin pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
    for (int it = 0; it < 400; it++) begin
      logic [N-1:0]    v;
      logic [N*AW-1:0] a;
      logic [N*DW-1:0] d;
      logic            h;
      int              g;
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1;
          pa[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          pd[i] = $urandom;
        end
        v[i] = pv[i];
        a[i*AW +: AW] = pa[i];
        d[i*DW +: DW] = pd[i];
      end
      h = ($urandom_range(0, 3) == 0);
      g = -1;
      if (!h) begin
        for (int off = 0; off < N; off++) begin
          int idx;
          idx = (m_ptr + off) % N;
          if (g < 0 && pv[idx]) g = idx;
        end
      end
      apply(h, v, a, d, o_rdy, o_we, o_fv, o_wa, o_wd, o_gid);
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        m_waddr = pa[g];
        m_wdata = pd[g];
        m_gid = g;
        m_we = (pa[g] != 0);
        pv[g] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      chk("rnd_ready", 32'(o_rdy), (g < 0) ? 32'h0 : (32'h1 << g));
      chk("rnd_we", 32'(o_we), 32'(m_we));
      chk("rnd_fwd", 32'(o_fv), 32'(m_we));
      chk("rnd_waddr", 32'(o_wa), 32'(m_waddr));
      chk("rnd_wdata", o_wd, m_wdata);
      chk("rnd_gid", 32'(o_gid), 32'(m_gid));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
